// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the CPU control path and the multiply/divide unit.
// Optional MDU_DIV_ZERO_FLAG_EN adds the div_zero status line.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand0;
  logic [WIDTH-1:0] operand1;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_DIV_ZERO_FLAG_EN
  logic             div_zero;
`endif

  modport master (
    output start, op, operand0, operand1, hi_we, lo_we, wdata,
`ifdef MDU_DIV_ZERO_FLAG_EN
    input  div_zero,
`endif
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand0, operand1, hi_we, lo_we, wdata,
`ifdef MDU_DIV_ZERO_FLAG_EN
    output div_zero,
`endif
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers, one bit per cycle.
// Optional macro MDU_DIV_ZERO_FLAG_EN enables the registered div_zero flag.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  // Upper half: partial product / remainder; lower half: multiplier / quotient.
  logic [2*WIDTH-1:0] work_q;
  logic [WIDTH-1:0]   opb_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               is_div_q;
  logic               div0_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_d;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] div_next_d;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  // Operand magnitudes, one iteration step for each datapath, and final sign fix-up.
  always_comb begin
    a_neg_s     = ~bus.op[0] & bus.operand0[WIDTH-1];
    b_neg_s     = ~bus.op[0] & bus.operand1[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = -bus.operand0;
    end else begin
      a_mag_s = bus.operand0;
    end
    if (b_neg_s) begin
      b_mag_s = -bus.operand1;
    end else begin
      b_mag_s = bus.operand1;
    end

    if (work_q[0]) begin
      mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    end else begin
      mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]};
    end
    mul_next_d  = {mul_sum_s, work_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so a WIDTH+1 bit difference carries a valid sign.
    div_shift_s = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_q};
    if (div_diff_s[WIDTH]) begin
      div_next_d = {div_shift_s[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next_d = {div_diff_s[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    end

    if (neg_res_q) begin
      prod_fix_s = -work_q;
      quo_fix_s  = -work_q[WIDTH-1:0];
    end else begin
      prod_fix_s = work_q;
      quo_fix_s  = work_q[WIDTH-1:0];
    end
    if (neg_rem_q) begin
      rem_fix_s = -work_q[2*WIDTH-1:WIDTH];
    end else begin
      rem_fix_s = work_q[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, iteration datapath and HI/LO architectural state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      work_q     <= {(2*WIDTH){1'b0}};
      opb_q      <= {WIDTH{1'b0}};
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div0_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            busy_q <= 1'b1;
            opb_q  <= b_mag_s;
            cnt_q  <= CW'(WIDTH);
            if (!bus.op[1]) begin
              state_q   <= S_MUL;
              work_q    <= {{WIDTH{1'b0}}, a_mag_s};
              neg_res_q <= a_neg_s ^ b_neg_s;
              neg_rem_q <= 1'b0;
              is_div_q  <= 1'b0;
              div0_q    <= 1'b0;
            end else if (bus.operand1 == {WIDTH{1'b0}}) begin
              // Divide by zero: preload the architectural result and finish next edge.
              state_q   <= S_DONE;
              work_q    <= {bus.operand0, {WIDTH{1'b1}}};
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
              is_div_q  <= 1'b1;
              div0_q    <= 1'b1;
            end else begin
              state_q   <= S_DIV;
              work_q    <= {{WIDTH{1'b0}}, a_mag_s};
              neg_res_q <= a_neg_s ^ b_neg_s;
              neg_rem_q <= a_neg_s;
              is_div_q  <= 1'b1;
              div0_q    <= 1'b0;
            end
          end
        end
        S_MUL: begin
          work_q <= mul_next_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_DONE;
        end
        S_DIV: begin
          work_q <= div_next_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_DONE;
        end
        S_DONE: begin
          if (is_div_q) begin
            hi_q <= rem_fix_s;
            lo_q <= quo_fix_s;
          end else begin
            hi_q <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix_s[WIDTH-1:0];
          end
          done_q     <= 1'b1;
          div_zero_q <= div0_q;
          busy_q     <= 1'b0;
          cnt_q      <= {CW{1'b0}};
          state_q    <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MDU_DIV_ZERO_FLAG_EN
  assign bus.div_zero = div_zero_q;
`else
  logic unused_div_zero_s;
  assign unused_div_zero_s = div_zero_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops against an arithmetic model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic, truncated to W bits.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: begin up = longint'(sa * sb); eh = up[63:32]; el = up[31:0]; end
      2'b01: begin up = ua * ub;           eh = up[63:32]; el = up[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin sq = sa / sb; sr = sa % sb; eh = sr[31:0]; el = sq[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin up = ua / ub; eh = 32'(ua % ub); el = up[31:0]; end
      end
    endcase
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    logic [W-1:0] eh, el, h0, l0;
    int cyc;
    bit bad;
    bit dz;
    model(op, a, b, eh, el);
    dz  = op[1] && (b == 32'd0);
    bad = 1'b0;
    @(negedge clk);
    h0 = bus.hi; l0 = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.operand0 = a; bus.operand1 = b;
    @(posedge clk); #1;
    check({tag, ".busy_start"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.operand0 = $urandom; bus.operand1 = $urandom;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done !== 1'b1 && (bus.busy !== 1'b1 || bus.hi !== h0 || bus.lo !== l0)) bad = 1'b1;
    end
    check({tag, ".latency"}, 64'(cyc), dz ? 64'd1 : 64'd33);
    check({tag, ".hold"}, 64'(bad), 64'd0);
    check({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
    check({tag, ".hi"}, 64'(bus.hi), 64'(eh));
    check({tag, ".lo"}, 64'(bus.lo), 64'(el));
`ifdef MDU_DIV_ZERO_FLAG_EN
    check({tag, ".div_zero"}, 64'(bus.div_zero), 64'(dz));
`endif
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.operand0 = 32'd0; bus.operand1 = 32'd0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.hi", 64'(bus.hi), 64'd0);
    check("rst.lo", 64'(bus.lo), 64'd0);
    @(negedge clk); rst = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, "multu_max");
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, "mult_neg");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
    run_op(2'b11, 32'd100, 32'd7, "divu_100_7");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b11, 32'h1234_5678, 32'd0, "divu_zero");
    run_op(2'b10, 32'h8765_4321, 32'd0, "div_zero");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

    // Start and busy-time writes must be ignored while the unit is busy.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.operand0 = 32'd3; bus.operand1 = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.operand0 = 32'd7; bus.operand1 = 32'd7;
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_AAAA;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(cyc);
    check("busy_ign.done", 64'(bus.done), 64'd1);
    check("busy_ign.hi", 64'(bus.hi), 64'd0);
    check("busy_ign.lo", 64'(bus.lo), 64'd15);
    @(negedge clk);
    check("busy_ign.idle", 64'(bus.busy), 64'd0);
    bus.lo_we = 1'b1; bus.wdata = 32'h0000_0055;
    @(posedge clk); #1;
    check("mtlo.lo", 64'(bus.lo), 64'h55);
    check("mtlo.hi", 64'(bus.hi), 64'd0);
    @(negedge clk); bus.lo_we = 1'b0;

    // MTHI in the start cycle lands first, then the result overwrites it.
    bus.start = 1'b1; bus.op = 2'b01; bus.operand0 = 32'd2; bus.operand1 = 32'd3;
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    check("mthi_start.hi", 64'(bus.hi), 64'h1234);
    @(negedge clk); bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(cyc);
    check("mthi_start.done", 64'(bus.done), 64'd1);
    check("mthi_start.res_hi", 64'(bus.hi), 64'd0);
    check("mthi_start.res_lo", 64'(bus.lo), 64'd6);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.lo_we = 1'b0;
    bus.start = 1'b1; bus.op = 2'b11; bus.operand0 = 32'd1000; bus.operand1 = 32'd7;
    @(negedge clk); bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst.busy", 64'(bus.busy), 64'd0);
    check("arst.done", 64'(bus.done), 64'd0);
    check("arst.hi", 64'(bus.hi), 64'd0);
    check("arst.lo", 64'(bus.lo), 64'd0);
    @(negedge clk); rst = 1'b1;
    run_op(2'b11, 32'd9, 32'd3, "divu_9_3");

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rop, ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
